// File: rtl/edge_detect_pkg.sv
// Shared definitions for the multi-channel edge detector: the per-channel
// mode field type and its encodings.
package edge_detect_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

  // Select the reported edge for one channel from its rise/fall pulses.
  function automatic logic mode_select(mode_t mode, logic rise, logic fall);
    logic sel;
    case (mode)
      MODE_OFF:  sel = 1'b0;
      MODE_RISE: sel = rise;
      MODE_FALL: sel = fall;
      MODE_BOTH: sel = rise | fall;
      default:   sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One edge-detect channel: async-input synchroniser, consecutive-sample
// debounce filter, registered rise/fall/edge pulses and a sticky pending flag.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  sig_in,
  input  mode_t mode,
  input  logic  clr,
  output logic  level_out,
  output logic  rise_pulse,
  output logic  fall_pulse,
  output logic  edge_pulse,
  output logic  pending
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  // Count value at which the next differing sample commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   edge_q, edge_d;
  logic                   pending_q, pending_d;
  logic                   sync_val;
  logic                   update;

  // Synchroniser shift chain; stage 0 captures the raw asynchronous input.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sig_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Debounce: the level only moves after FILTER_LEN consecutive differing samples.
  always_comb begin
    sync_val = sync_q[SYNC_STAGES-1];
    cnt_d    = cnt_q;
    level_d  = level_q;
    update   = 1'b0;
    if (sync_val == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_val;
      cnt_d   = '0;
      update  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Pulses are computed with the level update so they align with the new level_out.
  always_comb begin
    rise_d = update & sync_val;
    fall_d = update & ~sync_val;
    edge_d = mode_select(mode, rise_d, fall_d);
  end

  // Sticky pending flag: a reported edge beats a simultaneous clear.
  always_comb begin
    if (edge_q) begin
      pending_d = 1'b1;
    end else if (clr) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State registers with synchronous reset discarding counts and in-flight pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      edge_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign edge_pulse = edge_q;
  assign pending    = pending_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: CH_NUM independent channels plus one
// OR-reduced interrupt request built from enabled pending flags.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH_NUM-1:0]   sig_in,
  input  logic [2*CH_NUM-1:0] mode,
  input  logic [CH_NUM-1:0]   clr,
  input  logic [CH_NUM-1:0]   irq_en,
  output logic [CH_NUM-1:0]   level_out,
  output logic [CH_NUM-1:0]   rise_pulse,
  output logic [CH_NUM-1:0]   fall_pulse,
  output logic [CH_NUM-1:0]   edge_pulse,
  output logic [CH_NUM-1:0]   pending,
  output logic                irq
);

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_chan
    edge_detect_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in[gi]),
      .mode       (mode[2*gi +: 2]),
      .clr        (clr[gi]),
      .level_out  (level_out[gi]),
      .rise_pulse (rise_pulse[gi]),
      .fall_pulse (fall_pulse[gi]),
      .edge_pulse (edge_pulse[gi]),
      .pending    (pending[gi])
    );
  end

  // Interrupt request follows pending directly so it adds no latency.
  always_comb begin
    irq = |(pending & irq_en);
  end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench: two instances (FILTER_LEN=1 and 4) share stimulus; a delay-line /
// sliding-window model predicts every output each cycle, plus literal checks.
module tb_edge_detect_multi;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FA = 1;
  localparam int FB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] sig_in, clr, irq_en;
  logic [2*CH-1:0] mode;

  logic [CH-1:0] lvl_a, rise_a, fall_a, edge_a, pend_a;
  logic [CH-1:0] lvl_b, rise_b, fall_b, edge_b, pend_b;
  logic          irq_a, irq_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  edge_detect_multi #(.CH_NUM(CH), .SYNC_STAGES(SS), .FILTER_LEN(FA)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode), .clr(clr), .irq_en(irq_en),
    .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .edge_pulse(edge_a), .pending(pend_a), .irq(irq_a));

  edge_detect_multi #(.CH_NUM(CH), .SYNC_STAGES(SS), .FILTER_LEN(FB)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode), .clr(clr), .irq_en(irq_en),
    .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .edge_pulse(edge_b), .pending(pend_b), .irq(irq_b));

  // ---------------- reference model ----------------
  bit raw_q[2][CH][$];   // raw samples since reset (last SS kept)
  bit syn_q[2][CH][$];   // synchronised samples seen by the filter (last FL kept)
  bit [CH-1:0] m_lvl[2], m_rise[2], m_fall[2], m_edge[2], m_pend[2];

  task automatic cmp(string nm, logic [CH-1:0] act, logic [CH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int fl;
      fl = (d == 0) ? FA : FB;
      for (int c = 0; c < CH; c++) begin
        bit s, upd;
        if (rst) begin
          raw_q[d][c].delete();
          syn_q[d][c].delete();
          m_lvl[d][c] = 1'b0; m_rise[d][c] = 1'b0; m_fall[d][c] = 1'b0;
          m_edge[d][c] = 1'b0; m_pend[d][c] = 1'b0;
        end else begin
          // pending reacts to the edge pulse visible during this cycle
          if (m_edge[d][c]) m_pend[d][c] = 1'b1;
          else if (clr[c]) m_pend[d][c] = 1'b0;
          // value leaving the synchroniser: raw input sampled SS edges ago
          s = (raw_q[d][c].size() >= SS) ? raw_q[d][c][raw_q[d][c].size() - SS] : 1'b0;
          raw_q[d][c].push_back(sig_in[c]);
          if (raw_q[d][c].size() > SS) void'(raw_q[d][c].pop_front());
          syn_q[d][c].push_back(s);
          if (syn_q[d][c].size() > fl) void'(syn_q[d][c].pop_front());
          // level flips when the last fl filter samples all disagree with it
          upd = (syn_q[d][c].size() == fl);
          foreach (syn_q[d][c][k]) if (syn_q[d][c][k] == m_lvl[d][c]) upd = 1'b0;
          if (upd) m_lvl[d][c] = s;
          m_rise[d][c] = upd & s;
          m_fall[d][c] = upd & ~s;
          m_edge[d][c] = (m_rise[d][c] & mode[2*c]) | (m_fall[d][c] & mode[2*c+1]);
        end
      end
    end
  endtask

  // Per-cycle compare: model advances on the edge, DUT outputs checked 1 unit later.
  initial begin : compare_proc
    forever begin
      @(posedge clk);
      model_step();
      #1;
      cmp("level_a", lvl_a,  m_lvl[0]);
      cmp("rise_a",  rise_a, m_rise[0]);
      cmp("fall_a",  fall_a, m_fall[0]);
      cmp("edge_a",  edge_a, m_edge[0]);
      cmp("pend_a",  pend_a, m_pend[0]);
      cmp("irq_a",   {3'b000, irq_a}, {3'b000, |(m_pend[0] & irq_en)});
      cmp("level_b", lvl_b,  m_lvl[1]);
      cmp("rise_b",  rise_b, m_rise[1]);
      cmp("fall_b",  fall_b, m_fall[1]);
      cmp("edge_b",  edge_b, m_edge[1]);
      cmp("pend_b",  pend_b, m_pend[1]);
      cmp("irq_b",   {3'b000, irq_b}, {3'b000, |(m_pend[1] & irq_en)});
    end
  end

  // advance to 2 units after the next rising edge (after the compare point)
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    rst    = 1'b1;
    sig_in = 4'b0000;
    clr    = 4'b0000;
    irq_en = 4'b0001;
    mode   = {2'b11, 2'b10, 2'b11, 2'b01};
    tick(3);
    cmp("lit_reset_level", lvl_a, 4'b0000);
    cmp("lit_reset_pend",  pend_a, 4'b0000);
    cmp("lit_reset_irq",   {3'b000, irq_a}, 4'b0000);

    // reset release with ch0 rising before edge 1
    rst = 1'b0;
    sig_in[0] = 1'b1;
    tick(3);
    cmp("lit_rel_level0", {3'b000, lvl_a[0]},  4'b0001);
    cmp("lit_rel_rise0",  {3'b000, rise_a[0]}, 4'b0001);
    cmp("lit_rel_edge0",  {3'b000, edge_a[0]}, 4'b0001);
    tick(1);
    cmp("lit_rel_rise0_off", {3'b000, rise_a[0]}, 4'b0000);
    cmp("lit_rel_pend0",  {3'b000, pend_a[0]}, 4'b0001);
    cmp("lit_rel_irq",    {3'b000, irq_a}, 4'b0001);

    // glitch rejection on ch1 (FILTER_LEN=4 instance)
    sig_in[1] = 1'b1;
    tick(3);
    sig_in[1] = 1'b0;
    tick(8);
    cmp("lit_glitch_level1", {3'b000, lvl_b[1]}, 4'b0000);
    sig_in[1] = 1'b1;
    tick(5);
    cmp("lit_filt_early1", {3'b000, lvl_b[1]}, 4'b0000);
    tick(1);
    cmp("lit_filt_level1", {3'b000, lvl_b[1]},  4'b0001);
    cmp("lit_filt_rise1",  {3'b000, rise_b[1]}, 4'b0001);

    // mode selection on ch2 (mode 10)
    sig_in[2] = 1'b1;
    tick(3);
    cmp("lit_m10_rise2", {3'b000, rise_a[2]}, 4'b0001);
    cmp("lit_m10_edge_r", {3'b000, edge_a[2]}, 4'b0000);
    tick(2);
    sig_in[2] = 1'b0;
    tick(3);
    cmp("lit_m10_fall2", {3'b000, fall_a[2]}, 4'b0001);
    cmp("lit_m10_edge_f", {3'b000, edge_a[2]}, 4'b0001);
    tick(1);
    cmp("lit_m10_pend2", {3'b000, pend_a[2]}, 4'b0001);
    mode[5:4] = 2'b00;
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    cmp("lit_clr_pend2", {3'b000, pend_a[2]}, 4'b0000);
    sig_in[2] = 1'b1;
    tick(3);
    cmp("lit_m00_rise2", {3'b000, rise_a[2]}, 4'b0001);
    cmp("lit_m00_edge2", {3'b000, edge_a[2]}, 4'b0000);
    sig_in[2] = 1'b0;
    tick(3);
    cmp("lit_m00_fall2", {3'b000, fall_a[2]}, 4'b0001);
    tick(1);
    cmp("lit_m00_pend2", {3'b000, pend_a[2]}, 4'b0000);

    // set/clear collision on ch3 (mode 11)
    irq_en = 4'b1000;
    clr = 4'b1111;
    tick(1);
    clr = 4'b0000;
    sig_in[3] = 1'b1;
    tick(3);
    cmp("lit_col_edge3", {3'b000, edge_a[3]}, 4'b0001);
    clr[3] = 1'b1;
    tick(1);
    cmp("lit_col_pend3", {3'b000, pend_a[3]}, 4'b0001);
    tick(1);
    cmp("lit_col_clr3", {3'b000, pend_a[3]}, 4'b0000);
    cmp("lit_col_irq",  {3'b000, irq_a}, 4'b0000);
    clr = 4'b0000;

    // reset in the middle of filtering (FILTER_LEN=4 instance, ch1)
    sig_in = 4'b0000;
    tick(12);
    sig_in[1] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    cmp("lit_mid_level", lvl_b,  4'b0000);
    cmp("lit_mid_rise",  rise_b, 4'b0000);
    rst = 1'b0;
    tick(5);
    cmp("lit_mid_early1", {3'b000, lvl_b[1]}, 4'b0000);
    tick(1);
    cmp("lit_mid_level1", {3'b000, lvl_b[1]},  4'b0001);
    cmp("lit_mid_rise1",  {3'b000, rise_b[1]}, 4'b0001);

    // parallel events on all channels with mode 11
    tick(12);
    mode = 8'hFF;
    clr  = 4'b1111;
    tick(1);
    clr  = 4'b0000;
    sig_in = ~sig_in;
    tick(3);
    cmp("lit_par_edge",  edge_a, 4'b1111);
    cmp("lit_par_level", lvl_a,  4'b1101);
    tick(1);
    cmp("lit_par_pend",  pend_a, 4'b1111);

    // randomized phase
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(5, 0) == 0) sig_in[c] = ~sig_in[c];
      end
      clr = ($urandom_range(7, 0) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(49, 0) == 0) mode = 8'($urandom);
      if ($urandom_range(19, 0) == 0) irq_en = 4'($urandom);
      rst = ($urandom_range(199, 0) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
